// File: rtl/ring_johnson_counter.sv
// WIDTH-bit shift counter: run-time ring / Johnson sequence, direction, enable, load, terminal count.
// Define COUNTER_SELFCORRECT_EN to add illegal-state detection with one-cycle correction (err pulse).
module ring_johnson_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             err
);

    localparam logic [WIDTH-1:0] Home = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] step;
    logic             mode_q;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic             mode_change;
    logic             illegal;

    assign mode_change = (mode != mode_q);

    // Next value in the currently selected sequence and direction.
    always_comb begin
        step = cnt_q;
        case ({mode, dir})
            2'b00:   step = {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]};
            2'b01:   step = {cnt_q[0], cnt_q[WIDTH-1:1]};
            2'b10:   step = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
            default: step = {~cnt_q[0], cnt_q[WIDTH-1:1]};
        endcase
    end

`ifdef COUNTER_SELFCORRECT_EN
    logic [WIDTH-2:0] edges;
    logic             ring_legal;
    logic             johnson_legal;

    // Ring needs exactly one bit set; Johnson allows at most one adjacent-bit transition.
    always_comb begin
        edges         = cnt_q[WIDTH-2:0] ^ cnt_q[WIDTH-1:1];
        ring_legal    = (cnt_q != '0) && ((cnt_q & (cnt_q - Home)) == '0);
        johnson_legal = ((edges & (edges - (WIDTH-1)'(1))) == '0);
        illegal       = mode_q ? ~johnson_legal : ~ring_legal;
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        err_d = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (mode_change) begin
            cnt_d = Home;
        end else if (illegal) begin
            cnt_d = Home;
            err_d = 1'b1;
        end else if (en) begin
            cnt_d = step;
            tc_d  = (step == Home);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= Home;
            mode_q <= 1'b0;
            tc_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode;
            tc_q   <= tc_d;
            err_q  <= err_d;
        end
    end

    assign q   = cnt_q;
    assign tc  = tc_q;
    assign err = err_q;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Scoreboard bench for ring_johnson_counter (WIDTH = 4): directed test-plan sequences plus
// randomized traffic checked against an arithmetic reference model.
module tb_ring_johnson_counter;

    localparam int W = 4;
`ifdef COUNTER_SELFCORRECT_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] q;
        logic         tc;
        logic         err;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         en;
    logic         mode;
    logic         dir;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic         tc;
    logic         err;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m_q;
    bit           m_mode_q;

    ring_johnson_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference sequences computed with integer rotate/shift arithmetic.
    function automatic logic [W-1:0] seq_next(input logic [W-1:0] s, input bit md, input bit dr);
        int v;
        int mask;
        int r;
        v    = int'(s);
        mask = (1 << W) - 1;
        if (!md && !dr)     r = ((v << 1) | (v >> (W - 1))) & mask;
        else if (!md && dr) r = ((v >> 1) | ((v & 1) << (W - 1))) & mask;
        else if (md && !dr) r = ((v << 1) & mask) | (((v >> (W - 1)) & 1) ^ 1);
        else                r = (v >> 1) | (((v & 1) ^ 1) << (W - 1));
        return r[W-1:0];
    endfunction

    function automatic bit is_legal(input logic [W-1:0] s, input bit md);
        logic [W-1:0] lo;
        lo        = '1;
        lo[W-1]   = 1'b0;
        if (!md) return ($countones(s) == 1);
        return ($countones((s ^ (s >> 1)) & lo) <= 1);
    endfunction

    // Drives one cycle of inputs at the falling edge and advances the model for the next rising edge.
    task automatic drive(input bit e, input bit m, input bit d, input bit l,
                         input logic [W-1:0] lv, output exp_t mexp);
        @(negedge clk);
        reset    = 1'b1;
        en       = e;
        mode     = m;
        dir      = d;
        load     = l;
        load_val = lv;
        mexp.tc  = 1'b0;
        mexp.err = 1'b0;
        if (l) begin
            m_q = lv;
        end else if (m != m_mode_q) begin
            m_q = W'(1);
        end else if (SC && !is_legal(m_q, m_mode_q)) begin
            m_q      = W'(1);
            mexp.err = 1'b1;
        end else if (e) begin
            m_q     = seq_next(m_q, m, d);
            mexp.tc = (m_q == W'(1));
        end
        m_mode_q = m;
        mexp.q   = m_q;
    endtask

    task automatic dstep(input bit e, input bit m, input bit d, input bit l, input logic [W-1:0] lv,
                         input logic [W-1:0] eq, input bit etc, input bit eerr);
        exp_t mexp;
        exp_t c;
        drive(e, m, d, l, lv, mexp);
        c.q   = eq;
        c.tc  = etc;
        c.err = eerr;
        sb.push_back(c);
    endtask

    task automatic rstep(input bit e, input bit m, input bit d, input bit l, input logic [W-1:0] lv);
        exp_t mexp;
        drive(e, m, d, l, lv, mexp);
        sb.push_back(mexp);
    endtask

    task automatic assert_reset(input string tag);
        @(negedge clk);
        #2;
        reset    = 1'b0;
        m_q      = W'(1);
        m_mode_q = 1'b0;
        #1;
        chk({tag, "_q"}, int'(q), 1);
        chk({tag, "_tc"}, int'(tc), 0);
        chk({tag, "_err"}, int'(err), 0);
        @(posedge clk);
        #2;
        chk({tag, "_hold_q"}, int'(q), 1);
        chk({tag, "_hold_tc"}, int'(tc), 0);
    endtask

    // Monitor: one registered result per rising edge while the scoreboard holds expectations.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("q", int'(q), int'(e.q));
                chk("tc", int'(tc), int'(e.tc));
                chk("err", int'(err), int'(e.err));
            end
        end
    end

    initial begin
        logic [W-1:0] jf[8];
        logic [W-1:0] jr[8];
        bit           cur_mode;
        bit           cur_dir;

        jf = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
        jr = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

        reset    = 1'b0;
        en       = 1'b0;
        mode     = 1'b0;
        dir      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        m_q      = W'(1);
        m_mode_q = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("init_q", int'(q), 1);
        chk("init_tc", int'(tc), 0);
        chk("init_err", int'(err), 0);

        // Ring forward, tc every 4 cycles on q = 0001.
        for (int i = 0; i < 8; i++) begin
            dstep(1, 0, 0, 0, '0, W'(1 << ((i + 1) % 4)), (i % 4) == 3, 0);
        end

        // Johnson forward: first edge is a mode change, then period 8.
        dstep(1, 1, 0, 0, '0, 4'b0001, 0, 0);
        for (int i = 0; i < 8; i++) dstep(1, 1, 0, 0, '0, jf[i], i == 7, 0);
        for (int i = 0; i < 8; i++) dstep(1, 1, 1, 0, '0, jr[i], i == 7, 0);

        // Mode toggle mid-count re-initialises without tc.
        dstep(1, 0, 0, 0, '0, 4'b0001, 0, 0);
        dstep(1, 0, 0, 0, '0, 4'b0010, 0, 0);
        dstep(1, 0, 0, 0, '0, 4'b0100, 0, 0);
        dstep(1, 1, 0, 0, '0, 4'b0001, 0, 0);
        dstep(1, 1, 0, 0, '0, 4'b0011, 0, 0);

        // Illegal ring load (also overrides the concurrent mode change).
        dstep(0, 0, 0, 1, 4'b0101, 4'b0101, 0, 0);
        if (SC) begin
            dstep(0, 0, 0, 0, '0, 4'b0001, 0, 1);
            dstep(0, 0, 0, 0, '0, 4'b0001, 0, 0);
            dstep(1, 0, 0, 1, 4'b0101, 4'b0101, 0, 0);
            dstep(1, 0, 0, 0, '0, 4'b0001, 0, 1);
            dstep(1, 0, 0, 0, '0, 4'b0010, 0, 0);
        end else begin
            dstep(0, 0, 0, 0, '0, 4'b0101, 0, 0);
            dstep(1, 0, 0, 0, '0, 4'b1010, 0, 0);
            dstep(1, 0, 0, 0, '0, 4'b0101, 0, 0);
            dstep(1, 0, 0, 0, '0, 4'b1010, 0, 0);
        end

        // Load on the same edge as a mode toggle; next step follows Johnson rules.
        dstep(1, 1, 0, 1, 4'b0010, 4'b0010, 0, 0);
        dstep(1, 1, 0, 0, '0, SC ? 4'b0001 : 4'b0101, 0, SC);
        dstep(0, 1, 0, 1, 4'b0001, 4'b0001, 0, 0);

        // Asynchronous reset while q = 1000, then hold with en = 0.
        dstep(0, 0, 0, 1, 4'b1000, 4'b1000, 0, 0);
        dstep(0, 0, 0, 0, '0, 4'b1000, 0, 0);
        en   = 1'b0;
        mode = 1'b0;
        assert_reset("rst_mid");
        for (int i = 0; i < 3; i++) dstep(0, 0, 0, 0, '0, 4'b0001, 0, 0);

        // Release with mode = 1: first edge is a silent re-initialisation.
        dstep(1, 1, 0, 0, '0, 4'b0001, 0, 0);
        dstep(1, 1, 0, 0, '0, 4'b0011, 0, 0);
        assert_reset("rst_m1");
        dstep(1, 1, 0, 0, '0, 4'b0001, 0, 0);
        dstep(1, 1, 0, 0, '0, 4'b0011, 0, 0);

        // Randomized traffic against the model.
        cur_mode = 1'b1;
        cur_dir  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) cur_mode = ~cur_mode;
            if ($urandom_range(0, 5) == 0) cur_dir = ~cur_dir;
            rstep($urandom_range(0, 3) != 0, cur_mode, cur_dir,
                  $urandom_range(0, 11) == 0, W'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ring_johnson_counter.md
# ring_johnson_counter

Parametrised shift-register counter, successor to the fixed 4-bit ring counter. Supports run-time selection between ring (one-hot rotate) and Johnson (twisted-ring) sequences, count direction, enable, and parallel load, and raises a terminal-count pulse. It is used as a sequence and phase generator in control paths.

## Interface
- WIDTH, 4, counter width in bits; legal range 2 to 32.
- clk  input  1  counter clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  step enable; when low, q holds (subject to the priorities in Operation).
- mode  input  1  sequence mode; 0 = ring, 1 = Johnson.
- dir  input  1  direction; 0 = forward, 1 = reverse.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value written to q when load is sampled high.
- q  output  WIDTH  counter state, registered.
- tc  output  1  terminal-count pulse, registered.
- err  output  1  illegal-state correction pulse, registered; tied to 0 when the feature is compiled out.

## Operation
- The home state is q = 1 (bit 0 set, all others clear). It is legal in both modes.
- Ring forward: q <= {q[W-2:0], q[W-1]}.
- Ring reverse: q <= {q[0], q[W-1:1]}.
- Johnson forward: q <= {q[W-2:0], ~q[W-1]}.
- Johnson reverse: q <= {~q[0], q[W-1:1]}.
- Sequence period is WIDTH steps in ring mode and 2*WIDTH steps in Johnson mode, in either direction.
- An internal register mode_q holds the previously sampled mode.
  - mode_q resets to 0.
  - A mode change is defined as mode != mode_q at the clock edge.
- Per-edge priority, highest first:
  1. load: q <= load_val, accepted verbatim (legal or not).
  2. mode change: q <= 1, regardless of en.
  3. illegal-state correction (only when COUNTER_SELFCORRECT_EN is defined): q <= 1, regardless of en.
  4. en: q <= next sequence value for the current mode and dir.
  5. Otherwise: hold.
- mode_q <= mode on every edge.
- tc is set to 1 on an edge where action 4 produces q = 1; otherwise tc is 0.
  - Reset, load, mode re-initialisation and correction never raise tc.
- err is set to 1 on an edge where action 3 fires; otherwise err is 0.
- dir may change on any cycle. The next step uses the new dir with no re-initialisation.

## Timing
- Reset (reset low) acts immediately, without waiting for a clock edge:
  - q = 1, tc = 0, err = 0, mode_q = 0.
  - This holds throughout reset, including reset asserted mid-count.
- Reset release is synchronous to the design: the first rising edge after reset goes high is the first active edge.
- If mode = 1 at reset release, the first edge is treated as a mode change: q <= 1 (no visible change), tc = 0.
- Latency:
  - Each step, load and re-initialisation takes one clock: the value appears on q after the rising edge.
  - tc and err align with the q value that caused them and last exactly one cycle per event.
- Simultaneous load and mode change: load wins, and mode_q still updates. A loaded value is therefore not overwritten by a re-initialisation.
- When en is held high continuously in a legal state, tc asserts once every WIDTH (ring) or 2*WIDTH (Johnson) cycles.

## Configuration
- Macro: COUNTER_SELFCORRECT_EN.
- When defined:
  - Legal ring state: exactly one bit set.
  - Legal Johnson state: at most one position i (0 to W-2) where q[i] != q[i+1].
  - An illegal q, with no load or mode change on that edge, is replaced by 1 on the next edge, and err pulses.
  - Recovery is therefore one cycle after q becomes illegal.
- When not defined:
  - There is no legality check.
  - Illegal states circulate under the normal shift rules.
  - err is constant 0.

## Test plan
All scenarios use WIDTH = 4.
- Reset, then en=1, mode=0, dir=0 -> q = 0001, 0010, 0100, 1000, 0001, and so on; tc = 1 only in the cycles where q = 0001, every 4 cycles.
- mode=1, dir=0 from the home state -> q = 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; tc period is 8. With dir=1 -> q = 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001.
- Ring count reaches 0100, then mode toggles to 1 -> next q = 0001 with tc = 0; Johnson counting continues as 0011 and onwards.
- Ring mode, load=1 with load_val = 0101:
  - With the macro: q = 0101 for one cycle, then 0001 with err = 1 for one cycle (also with en = 0).
  - Without the macro: q = 0101, 1010, 0101, and so on; err stays 0.
- Load asserted on the same edge as a mode toggle, load_val = 0010 -> q = 0010 with no re-initialisation; the next enabled step follows the new mode.
- reset asserted asynchronously while q = 1000 -> q = 0001, tc = 0, err = 0 before the next edge; with en = 0 after release, q holds at 0001.
